// File: rtl/aes_decipher_block.sv
// ----------------------------------------------------------------------------
// aes_decipher_block
//
// Iterative AES-128 inverse cipher. One 128-bit ciphertext is decrypted per
// accepted `next` pulse in 61 cycles:
//   INIT  : AddRoundKey with key 10
//   per round (x10): ISR (InvShiftRows), SBOX (4 cycles, one 32-bit word per
//   cycle through the shared external inverse S-box), ARK (AddRoundKey, then
//   InvMixColumns except in the final round).
// Round keys come from an external key memory addressed by `round`, which
// counts down from NR to 0.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   reset      in   1    asynchronous active-low reset
//   next       in   1    start decryption of `block` (only honoured when idle)
//   block      in   128  ciphertext, captured when `next` is accepted
//   roundKey   in   128  round key for index `round` (combinational read)
//   round      out  4    round-key index requested from key memory
//   invSubIn   out  32   state word presented to the external inverse S-box
//   invSubOut  in   32   inverse S-box result for invSubIn
//   newBlock   out  128  plaintext result register
//   ready      out  1    high when idle and newBlock is valid
//
// Optional feature (macro AES_DEC_CBC_EN):
//   iv         in   128  initial chaining value
//   ivLoad     in   1    load iv into the chain register (idle only, wins
//                        over `next`)
//   On completion the plaintext is XORed with the chain register and the
//   chain register takes the ciphertext of the finished block (CBC decrypt).
// ----------------------------------------------------------------------------
module aes_decipher_block #(
  parameter int unsigned NR = 32'd10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic [127:0] block,
  input  logic [127:0] roundKey,
  output logic [3:0]   round,
  output logic [31:0]  invSubIn,
  input  logic [31:0]  invSubOut,
`ifdef AES_DEC_CBC_EN
  input  logic [127:0] iv,
  input  logic         ivLoad,
`endif
  output logic [127:0] newBlock,
  output logic         ready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ISR  = 3'd2,
    SBOX = 3'd3,
    ARK  = 3'd4
  } fsm_t;

  localparam logic [3:0] LAST_KEY = 4'(NR);

  // GF(2^8) multiply by x, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; byte 0 is bits 31:24
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
            inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
  endfunction

  // Byte (row r, column c) lives at index 4c+r; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  fsm_t         fsm_r;
  logic [127:0] state_r;
  logic [1:0]   cnt_r;
  logic [127:0] ark_s;
  logic [127:0] imc_s;
  logic [127:0] isr_s;
  logic [127:0] sub_state_s;
  logic [31:0]  next_word_s;
  logic [127:0] result_s;
`ifdef AES_DEC_CBC_EN
  logic [127:0] chain_r;
  logic [127:0] cipher_r;
`endif

  assign ark_s = state_r ^ roundKey;
  assign imc_s = inv_mix_columns(ark_s);
  assign isr_s = inv_shift_rows(state_r);

`ifdef AES_DEC_CBC_EN
  assign result_s = ark_s ^ chain_r;
`else
  assign result_s = ark_s;
`endif

  // Substitute the current word with the S-box result and pick the word
  // the S-box must see next (the following word is still untouched)
  always_comb begin
    sub_state_s = state_r;
    next_word_s = 32'h0;
    case (cnt_r)
      2'd0: begin
        sub_state_s[127:96] = invSubOut;
        next_word_s         = state_r[95:64];
      end
      2'd1: begin
        sub_state_s[95:64]  = invSubOut;
        next_word_s         = state_r[63:32];
      end
      2'd2: begin
        sub_state_s[63:32]  = invSubOut;
        next_word_s         = state_r[31:0];
      end
      2'd3: begin
        sub_state_s[31:0]   = invSubOut;
        next_word_s         = 32'h0;
      end
      default: begin
        sub_state_s = state_r;
        next_word_s = 32'h0;
      end
    endcase
  end

  // Round sequencer: state, counters and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_r    <= IDLE;
      state_r  <= 128'h0;
      cnt_r    <= 2'd0;
      round    <= 4'd0;
      invSubIn <= 32'h0;
      newBlock <= 128'h0;
      ready    <= 1'b1;
`ifdef AES_DEC_CBC_EN
      chain_r  <= 128'h0;
      cipher_r <= 128'h0;
`endif
    end else begin
      case (fsm_r)
        IDLE: begin
`ifdef AES_DEC_CBC_EN
          if (ivLoad) begin
            chain_r <= iv;
          end else
`endif
          if (next) begin
            state_r  <= block;
            round    <= LAST_KEY;
            ready    <= 1'b0;
            fsm_r    <= INIT;
`ifdef AES_DEC_CBC_EN
            cipher_r <= block;
`endif
          end else begin
            fsm_r <= IDLE;
          end
        end
        INIT: begin
          state_r <= ark_s;
          round   <= LAST_KEY - 4'd1;
          fsm_r   <= ISR;
        end
        ISR: begin
          state_r  <= isr_s;
          cnt_r    <= 2'd0;
          invSubIn <= isr_s[127:96];
          fsm_r    <= SBOX;
        end
        SBOX: begin
          state_r  <= sub_state_s;
          cnt_r    <= cnt_r + 2'd1;
          invSubIn <= next_word_s;
          if (cnt_r == 2'd3) begin
            fsm_r <= ARK;
          end else begin
            fsm_r <= SBOX;
          end
        end
        ARK: begin
          if (round != 4'd0) begin
            state_r <= imc_s;
            round   <= round - 4'd1;
            fsm_r   <= ISR;
          end else begin
            // Final round: no InvMixColumns, publish the plaintext
            newBlock <= result_s;
            ready    <= 1'b1;
            fsm_r    <= IDLE;
`ifdef AES_DEC_CBC_EN
            chain_r  <= cipher_r;
`endif
          end
        end
        default: begin
          fsm_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decipher_block.sv
// ----------------------------------------------------------------------------
// tb_aes_decipher_block
//
// Self-checking bench for aes_decipher_block. Provides the key memory
// (expanded round keys) and the inverse S-box, keeps a byte-level AES model
// plus a cycle-timing model, compares ready/newBlock/round every cycle, and
// runs directed FIPS-197 / SP800-38A vectors. Define AES_DEC_CBC_EN to also
// exercise the chaining feature.
// ----------------------------------------------------------------------------
module tb_aes_decipher_block;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         reset;
  logic         next;
  logic [127:0] block;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [31:0]  inv_sub_in;
  logic [31:0]  inv_sub_out;
  logic [127:0] new_block;
  logic         ready;
`ifdef AES_DEC_CBC_EN
  logic [127:0] iv;
  logic         iv_load;
`endif

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [0:10];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  aes_decipher_block dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .block     (block),
    .roundKey  (round_key),
    .round     (round),
    .invSubIn  (inv_sub_in),
    .invSubOut (inv_sub_out),
`ifdef AES_DEC_CBC_EN
    .iv        (iv),
    .ivLoad    (iv_load),
`endif
    .newBlock  (new_block),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key memory and inverse S-box, both combinational
  always_comb round_key = (round <= 4'd10) ? rk[round] : 128'h0;
  assign inv_sub_out = {isbox[inv_sub_in[31:24]], isbox[inv_sub_in[23:16]],
                        isbox[inv_sub_in[15:8]],  isbox[inv_sub_in[7:0]]};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference AES (byte level) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv ? isbox[v[127 - 8*i -: 8]] : sbox[v[127 - 8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127 - 8*(4*c + r) -: 8] = v[127 - 8*(4*src + r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(m[(k - r + 4) % 4], v[127 - 8*(4*c + k) -: 8]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++)
      s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r >= 1; r--)
      s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[0];
  endfunction

  // ---------------- timing/result model ----------------
  logic         m_busy, m_ready;
  logic [127:0] m_nb, m_pending, m_ct, m_chain;
  logic [3:0]   m_round;
  int           m_j;

  // model: a job takes 61 edges; key index 10 first, then 9..0 six cycles each
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_ready <= 1'b1; m_nb <= 128'h0; m_round <= 4'd0;
      m_j <= 0; m_pending <= 128'h0; m_ct <= 128'h0; m_chain <= 128'h0;
    end else if (!m_busy) begin
`ifdef AES_DEC_CBC_EN
      if (iv_load) m_chain <= iv;
      else
`endif
      if (next) begin
        m_busy <= 1'b1; m_ready <= 1'b0; m_round <= 4'd10; m_j <= 0;
        m_pending <= aes_dec(block); m_ct <= block;
      end
    end else begin
      m_j <= m_j + 1;
      if (m_j + 1 == 61) begin
        m_busy <= 1'b0; m_ready <= 1'b1; m_round <= 4'd0;
        m_nb <= m_pending ^ m_chain;
`ifdef AES_DEC_CBC_EN
        m_chain <= m_ct;
`endif
      end else begin
        m_round <= 4'(9 - m_j / 6);
      end
    end
  end

  // compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    check("ready", {127'h0, ready}, {127'h0, m_ready});
    check("newBlock", new_block, m_nb);
    check("round", {124'h0, round}, {124'h0, m_round});
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready(input logic lvl, input int max, output int n);
    n = 0;
    while (ready !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", {127'h0, ready}, {127'h0, lvl});
  endtask

  task automatic pulse(input logic [127:0] blk);
    @(negedge clk); block = blk; next = 1'b1;
    @(negedge clk); next = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {127'h0, ready}, 128'h1);
    check("rst_newBlock", new_block, 128'h0);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_lo, prev_hi;
    logic [127:0] pt_cur, ct_cur, pt_exp, prev;
    logic [3:0]   last;
    logic [3:0]   seq [$];
    bit           seq_ok;

    reset = 1'b0; next = 1'b0; block = 128'h0;
`ifdef AES_DEC_CBC_EN
    iv = 128'h0; iv_load = 1'b0;
`endif
    build_tables();
    set_key(K1);
    check("model_dec_k1", aes_dec(CT1), PT1);
    check("model_enc_k1", aes_enc(PT1), CT1);
    set_key(K2);
    check("model_dec_k2", aes_dec(CT2), PT2);
    set_key(K1);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {127'h0, ready}, 128'h1);
    check("rst_newBlock", new_block, 128'h0);
    check("rst_round", {124'h0, round}, 128'h0);
    check("rst_invSubIn", {96'h0, inv_sub_in}, 128'h0);
    reset = 1'b1;

    // test 1: FIPS-197 C.1
    pulse(CT1);
    check("t1_busy", {127'h0, ready}, 128'h0);
    wait_ready(1'b1, 200, n);
    check("t1_latency", 128'(n), 128'd61);
    check("t1_pt", new_block, PT1);

    // test 2: FIPS-197 B, round index sequence
    set_key(K2); apply_reset();
    pulse(CT2);
    seq.delete(); seq.push_back(round); last = round; n = 0;
    while (!ready && n < 200) begin
      @(negedge clk); n++;
      if (round != last) begin seq.push_back(round); last = round; end
    end
    seq_ok = (seq.size() == 11);
    for (int i = 0; i < seq.size(); i++) if (seq[i] != 4'(10 - i)) seq_ok = 1'b0;
    check("t2_round_seq", {127'h0, seq_ok}, 128'h1);
    check("t2_pt", new_block, PT2);

    // test 3: second next mid-operation is ignored
    set_key(K1); apply_reset();
    pulse(CT1);
    repeat (19) @(negedge clk);
    block = CT2; next = 1'b1;
    @(negedge clk); next = 1'b0; block = 128'h0;
    wait_ready(1'b1, 200, n);
    check("t3_latency", 128'(20 + n), 128'd61);
    check("t3_pt", new_block, PT1);

    // test 4: reset mid-operation, then a clean run
    apply_reset();
    pulse(CT1);
    repeat (29) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t4_ready", {127'h0, ready}, 128'h1);
    check("t4_newBlock", new_block, 128'h0);
    @(negedge clk); reset = 1'b1;
    pulse(CT1);
    wait_ready(1'b1, 200, n);
    check("t4_latency", 128'(n), 128'd61);
    check("t4_pt", new_block, PT1);

    // test 5: loopback of 100 random blocks, next held high
    set_key(K2); apply_reset();
    prev = 128'h0; prev_hi = 0;
    pt_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef AES_DEC_CBC_EN
    ct_cur = aes_enc(pt_cur ^ prev);
`else
    ct_cur = aes_enc(pt_cur);
`endif
    @(negedge clk); block = ct_cur; next = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wait_ready(1'b0, 10, n_lo);
      if (i > 0) check("t5_spacing", 128'(n_lo + prev_hi), 128'd62);
      pt_exp = pt_cur;
      prev = ct_cur;
      pt_cur = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef AES_DEC_CBC_EN
      ct_cur = aes_enc(pt_cur ^ prev);
`else
      ct_cur = aes_enc(pt_cur);
`endif
      block = ct_cur;
      wait_ready(1'b1, 200, prev_hi);
      check("t5_pt", new_block, pt_exp);
      if (i == 99) next = 1'b0;
    end

`ifdef AES_DEC_CBC_EN
    // test 6: SP800-38A CBC-AES128 decrypt, ivLoad wins over next
    set_key(K2); apply_reset();
    @(negedge clk); iv = K1; iv_load = 1'b1; next = 1'b1; block = CT2;
    @(negedge clk); iv_load = 1'b0; next = 1'b0;
    check("t6_ivload_priority", {127'h0, ready}, 128'h1);
    pulse(128'h7649abac8119b246cee98e9b12e9197d);
    wait_ready(1'b1, 200, n);
    check("t6_pt1", new_block, 128'h6bc1bee22e409f96e93d7e117393172a);
    pulse(128'h5086cb9b507219ee95db113a917678b2);
    wait_ready(1'b1, 200, n);
    check("t6_pt2", new_block, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
